// File: rtl/div_unit.sv
`default_nettype none
// div_unit: multicycle restoring signed divider for MIPS DIV.
// Quotient goes to lo_out and remainder to hi_out; a zero divisor is flagged on div_zero.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        dividend,
    input  logic [WIDTH-1:0]        divisor,
    output logic [WIDTH-1:0]        lo_out,
    output logic [WIDTH-1:0]        hi_out,
    output logic                    busy,
    output logic                    done,
    output logic                    div_zero,
    output logic [$clog2(WIDTH):0]  counter
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ITER  = 3'd1;
    localparam logic [2:0] S_FIXUP = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] mag;
    logic             qneg;
    logic             rneg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;

    // The most negative operand negates to itself, which read unsigned is exactly its magnitude.
    assign abs_dividend = dividend[WIDTH-1] ? -dividend : dividend;
    assign abs_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;

    // The partial remainder stays below mag, so one extra bit is enough to see the borrow.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, mag};

    assign busy     = (state == S_ITER) || (state == S_FIXUP);
    assign done     = (state == S_DONE) || (state == S_ERR);
    assign div_zero = (state == S_ERR);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= S_IDLE;
            lo_out  <= '0;
            hi_out  <= '0;
            counter <= '0;
            quo     <= '0;
            rem     <= '0;
            mag     <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state <= S_ERR;
                        end else begin
                            quo     <= abs_dividend;
                            mag     <= abs_divisor;
                            rem     <= '0;
                            counter <= '0;
                            qneg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            rneg    <= dividend[WIDTH-1];
                            state   <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    quo     <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    rem     <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    counter <= counter + 1'b1;
                    if (counter == LAST) begin
                        state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    lo_out <= qneg ? -quo : quo;
                    hi_out <= rneg ? -rem : rem;
                    state  <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// tb_div_unit: randomized scoreboard bench for div_unit.
// Expected results come from plain signed 64-bit arithmetic.
module tb_div_unit;
    localparam int WIDTH = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] lo_out;
    logic [31:0] hi_out;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [5:0]  counter;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_lo = '0;
    logic [31:0] model_hi = '0;
    int          tests = 0;
    int          fails = 0;

    always #5 clock = ~clock;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .lo_out   (lo_out),
        .hi_out   (hi_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .counter  (counter)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse retires the oldest expected result.
    always @(negedge clock) begin
        if (reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("lo_out", 64'(lo_out), 64'(e.lo));
                    chk("hi_out", 64'(hi_out), 64'(e.hi));
                    chk("div_zero", 64'(div_zero), 64'(e.dz));
                end
            end else if (div_zero) begin
                chk("div_zero_without_done", 64'(div_zero), 64'd0);
            end
        end
    end

    // Issue one division; hold keeps start asserted while the unit is busy.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
        exp_t e;
        int   cyc;
        int   nbusy;
        int   lat;
        cyc   = 0;
        nbusy = 0;
        e.dz  = (b == 32'd0);
        if (e.dz) begin
            e.lo = model_lo;
            e.hi = model_hi;
        end else begin
            longint sa;
            longint sb;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            e.lo = 32'(sa / sb);
            e.hi = 32'(sa % sb);
            model_lo = e.lo;
            model_hi = e.hi;
        end
        exp_q.push_back(e);
        lat = e.dz ? 1 : WIDTH + 2;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        do begin
            @(negedge clock);
            cyc++;
            if (!hold) start = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
            if (busy) nbusy++;
        end while (!done && cyc < 60);
        chk("latency", 64'(cyc), 64'(lat));
        chk("busy_cycles", 64'(nbusy), e.dz ? 64'd0 : 64'(WIDTH + 1));
        start = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clock);
        chk("reset_lo_hi", {lo_out, hi_out}, 64'd0);
        chk("reset_flags", 64'({busy, done, div_zero, counter}), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        do_op(32'd100, 32'd7, 1'b0);
        do_op(32'(-100), 32'd7, 1'b0);
        do_op(32'd100, 32'(-7), 1'b0);
        do_op(32'd41, 32'd7, 1'b0);
        do_op(32'd1234, 32'd0, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(32'h8000_0000, 32'd1, 1'b0);

        // Abort a division mid-flight with reset.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (counter != 6'd10 && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        chk("counter_reaches_10", 64'(counter), 64'd10);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_lo_hi", {lo_out, hi_out}, 64'd0);
        chk("abort_flags", 64'({busy, done, div_zero, counter}), 64'd0);
        reset    = 1'b1;
        model_lo = '0;
        model_hi = '0;
        repeat (40) @(negedge clock);
        do_op(32'd9, 32'd3, 1'b0);

        // Start held high through the whole operation, then an immediate restart.
        do_op(32'd7, 32'd2, 1'b1);
        do_op(32'd50, 32'(-6), 1'b0);

        repeat (30) begin
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            sel = $urandom_range(0, 9);
            a   = (sel == 9) ? 32'h8000_0000 : 32'($urandom);
            if (sel == 0)      b = 32'd0;
            else if (sel == 9) b = 32'hFFFF_FFFF;
            else if (sel < 5)  b = $urandom_range(0, 1) ? 32'($urandom_range(1, 20))
                                                        : -32'($urandom_range(1, 20));
            else               b = ($urandom == 0) ? 32'd1 : 32'($urandom) | 32'd1;
            do_op(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
